// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the byte-serial load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_B:    return 4'd1;
      SZ_H:    return 4'd2;
      SZ_W:    return 4'd4;
      SZ_D:    return 4'd8;
      default: return 4'd1;
    endcase
  endfunction

  // Only the three low address bits can break natural alignment.
  function automatic logic misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return |addr_lo[1:0];
      SZ_D:    return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of an assembled load value to 64 bits.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [63:0] ext
);

  // Replicate the top bit of the loaded field unless zero-extending.
  always_comb begin
    ext = acc;
    case (size)
      SZ_B:    ext = {{56{~uns & acc[7]}},  acc[7:0]};
      SZ_H:    ext = {{48{~uns & acc[15]}}, acc[15:0]};
      SZ_W:    ext = {{32{~uns & acc[31]}}, acc[31:0]};
      SZ_D:    ext = acc;
      default: ext = acc;
    endcase
  end

endmodule

// File: rtl/lsu_byte_master.sv
// Byte-serial big-endian load/store master for a byte-wide data memory.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_byte_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e              state_r, state_s;
  logic                store_r, uns_r;
  logic [1:0]          size_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [63:0]         wdata_r;
  logic [2:0]          last_r, k_r, idx_s;
  logic [55:0]         acc_r;
  logic [63:0]         acc_s, ext_s;
  logic                err_s;
  logic                rsp_valid_r, rsp_err_r;
  logic [63:0]         rsp_rdata_r;

`ifdef LSU_MISALIGN_TRAP_EN
  assign err_s = misaligned(req_addr[2:0], req_size);
`else
  assign err_s = 1'b0;
`endif

  assign acc_s     = {acc_r, mem_rdata};
  assign idx_s     = last_r - k_r;
  assign req_ready = (state_r == ST_IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

  lsu_extend u_extend (
    .acc  (acc_s),
    .size (size_r),
    .uns  (uns_r),
    .ext  (ext_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_s = err_s ? ST_DONE : ST_XFER;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (k_r == last_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_XFER;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Request capture, byte counter and load assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_r <= 1'b0;
      size_r  <= SZ_B;
      uns_r   <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= 64'd0;
      last_r  <= 3'd0;
      k_r     <= 3'd0;
      acc_r   <= 56'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            store_r <= req_store;
            size_r  <= req_size;
            uns_r   <= req_unsigned;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            last_r  <= 3'(size_bytes(req_size) - 4'd1);
            k_r     <= 3'd0;
            acc_r   <= 56'd0;
          end
        end
        ST_XFER: begin
          k_r <= k_r + 3'd1;
          if (!store_r) begin
            acc_r <= acc_s[55:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Response registers: rdata is loaded on entry to DONE and held afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 64'd0;
    end else begin
      rsp_valid_r <= (state_s == ST_DONE);
      if (state_s == ST_DONE) begin
        rsp_err_r   <= (state_r == ST_IDLE) ? err_s : 1'b0;
        rsp_rdata_r <= (state_r == ST_XFER && !store_r) ? ext_s : 64'd0;
      end else begin
        rsp_err_r <= 1'b0;
      end
    end
  end

  // Memory port decode; byte (n-1-k) of the store data goes out first
  always_comb begin
    mem_addr  = {ADDR_W{1'b0}};
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (state_r == ST_XFER) begin
      mem_addr = addr_r + ADDR_W'(k_r);
      mem_re   = ~store_r;
      mem_we   = store_r;
      if (store_r) begin
        mem_wdata = wdata_r[{idx_s, 3'b000} +: 8];
      end else begin
        mem_wdata = 8'h00;
      end
    end else begin
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = 8'h00;
    end
  end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Directed table-driven bench for lsu_byte_master with a 64-byte memory model.
module tb_lsu_byte_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [5:0]  req_addr = 6'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid, rsp_err, mem_re, mem_we;
  logic [63:0] rsp_rdata;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  mem [64];

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [5:0]  ad;
    logic [63:0] wd;
    logic [63:0] exp;
    logic        err;
  } vec_t;

  vec_t vt[14];

  lsu_byte_master #(.ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  // Memory model: doubleword 0 holds 1000, bytes 8..63 hold their own address
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = (i < 8) ? 8'h00 : 8'(i);
    mem[6] = 8'h03;
    mem[7] = 8'hE8;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    int nb, cyc, nacc, rsp_cyc;
    logic got, tr_ok, er;
    logic [63:0] rd;
    string nm;
    nm = $sformatf("v%0d", id);
    nb = v.err ? 0 : (1 << v.sz);
    @(negedge clk);
    chk({nm, " ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_store = v.st; req_size = v.sz;
    req_unsigned = v.un; req_addr = v.ad; req_wdata = v.wd;
    @(posedge clk);
    #1 req_valid = 1'b0; req_wdata = 64'd0; req_addr = 6'd0;
    cyc = 0; got = 1'b0; nacc = 0; tr_ok = 1'b1; rsp_cyc = 0; rd = 64'd0; er = 1'b0;
    while (!got && cyc < 16) begin
      @(negedge clk);
      cyc++;
      if (mem_re || mem_we) begin
        if (cyc != nacc + 1 || mem_addr != 6'(int'(v.ad) + nacc) ||
            mem_re != !v.st || mem_we != v.st) tr_ok = 1'b0;
        nacc++;
      end
      if (rsp_valid) begin
        got = 1'b1; rd = rsp_rdata; er = rsp_err; rsp_cyc = cyc;
      end
    end
    chk({nm, " rsp seen"}, 64'(got), 64'd1);
    chk({nm, " rdata"}, rd, v.exp);
    chk({nm, " err"}, 64'(er), 64'(v.err));
    chk({nm, " rsp cycle"}, 64'(rsp_cyc), 64'(nb + 1));
    chk({nm, " access count"}, 64'(nacc), 64'(nb));
    chk({nm, " access trace"}, 64'(tr_ok), 64'd1);
    @(negedge clk);
    chk({nm, " pulse/ready"}, {62'd0, rsp_valid, req_ready}, 64'd1);
  endtask

  initial begin
    logic seen;
    vt[0]  = '{1'b0, SZ_D, 1'b0, 6'd0,  64'd0, 64'd1000, 1'b0};
    vt[1]  = '{1'b0, SZ_H, 1'b1, 6'd6,  64'd0, 64'h03E8, 1'b0};
    vt[2]  = '{1'b0, SZ_B, 1'b0, 6'd7,  64'd0, 64'hFFFF_FFFF_FFFF_FFE8, 1'b0};
    vt[3]  = '{1'b1, SZ_W, 1'b0, 6'd40, 64'h1234_5678_DEAD_BEEF, 64'd0, 1'b0};
    vt[4]  = '{1'b0, SZ_W, 1'b0, 6'd40, 64'd0, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0};
    vt[5]  = '{1'b0, SZ_H, 1'b0, 6'd42, 64'd0, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0};
    vt[6]  = '{1'b0, SZ_W, 1'b1, 6'd40, 64'd0, 64'h0000_0000_DEAD_BEEF, 1'b0};
    vt[7]  = '{1'b0, SZ_B, 1'b1, 6'd7,  64'd0, 64'h0000_0000_0000_00E8, 1'b0};
    vt[8]  = '{1'b1, SZ_H, 1'b0, 6'd20, 64'hFFFF_FFFF_FFFF_ABCD, 64'd0, 1'b0};
    vt[9]  = '{1'b0, SZ_H, 1'b1, 6'd20, 64'd0, 64'h0000_0000_0000_ABCD, 1'b0};
    vt[10] = '{1'b1, SZ_B, 1'b0, 6'd30, 64'hA5A5_A5A5_A5A5_A55A, 64'd0, 1'b0};
    vt[11] = '{1'b0, SZ_B, 1'b0, 6'd30, 64'd0, 64'h0000_0000_0000_005A, 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
    vt[12] = '{1'b0, SZ_D, 1'b0, 6'd3,  64'd0, 64'd0, 1'b1};
    vt[13] = '{1'b0, SZ_D, 1'b0, 6'd60, 64'd0, 64'd0, 1'b1};
`else
    vt[12] = '{1'b0, SZ_D, 1'b0, 6'd3,  64'd0, 64'h0000_0003_E808_090A, 1'b0};
    vt[13] = '{1'b0, SZ_D, 1'b0, 6'd60, 64'd0, 64'h3C3D_3E3F_0000_0000, 1'b0};
`endif

    repeat (2) @(negedge clk);
    chk("reset ctl", {45'd0, req_ready, rsp_valid, rsp_err, mem_re, mem_we, mem_addr, mem_wdata},
        {45'd0, 1'b1, 18'd0});
    chk("reset rdata", rsp_rdata, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) apply(vt[i], i);

    chk("mem 40..43", {32'd0, mem[40], mem[41], mem[42], mem[43]}, 64'h0000_0000_DEAD_BEEF);
    chk("mem 20..21", {48'd0, mem[20], mem[21]}, 64'h0000_0000_0000_ABCD);
    chk("mem 30", {56'd0, mem[30]}, 64'h0000_0000_0000_005A);

    // Reset in cycle 3 of a double store: bytes 0,1 land, byte 2 must not
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = SZ_D; req_unsigned = 1'b0;
    req_addr = 6'd0; req_wdata = 64'h1122_3344_5566_7788;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("cycle3 write", {55'd0, mem_we, mem_addr, mem_wdata}, {55'd0, 1'b1, 6'd2, 8'h33});
    rst_n = 1'b0;
    #1;
    chk("midrst ctl", {45'd0, req_ready, rsp_valid, rsp_err, mem_re, mem_we, mem_addr, mem_wdata},
        {45'd0, 1'b1, 18'd0});
    chk("midrst rdata", rsp_rdata, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid || mem_we || mem_re) seen = 1'b1;
    end
    chk("no rsp after rst", 64'(seen), 64'd0);
    chk("ready after rst", 64'(req_ready), 64'd1);
    chk("mem 0..2 after rst", {40'd0, mem[0], mem[1], mem[2]}, 64'h0000_0000_0011_2200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
